// File: rtl/array_multiplier_structural.sv
// Unsigned 4x4 array multiplier: AND-gate partial products summed by three
// ripple rows of half/full-adder cells, with a registered 8-bit product.

module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

module array_multiplier_structural (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] m,
  input  logic [3:0] q,
  output logic [7:0] p
);

  logic [3:0] pp    [4];
  logic [3:0] row_a [1:3];
  logic [3:0] row_s [1:3];
  logic [4:1] row_c [1:3];
  logic [7:0] sum;

  for (genvar i = 0; i < 4; i++) begin : g_pp
    assign pp[i] = m & {4{q[i]}};
  end

  // Row 1 adds to the upper bits of row 0; there is no carry yet, so its MSB input is 0.
  assign row_a[1] = {1'b0, pp[0][3:1]};

  for (genvar i = 2; i <= 3; i++) begin : g_row_in
    assign row_a[i] = {row_c[i-1][4], row_s[i-1][3:1]};
  end

  for (genvar i = 1; i <= 3; i++) begin : g_row
    for (genvar j = 0; j < 4; j++) begin : g_cell
      if (j == 0) begin : g_ha
        half_adder u_ha (
          .a (row_a[i][j]),
          .b (pp[i][j]),
          .s (row_s[i][j]),
          .c (row_c[i][j+1])
        );
      end else begin : g_fa
        full_adder u_fa (
          .a    (row_a[i][j]),
          .b    (pp[i][j]),
          .cin  (row_c[i][j]),
          .s    (row_s[i][j]),
          .cout (row_c[i][j+1])
        );
      end
    end
  end

  // Each row retires its LSB; the last row supplies bits 6:3 and its carry is bit 7.
  assign sum = {row_c[3][4], row_s[3], row_s[2][0], row_s[1][0], pp[0][0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      p <= 8'h00;
    end else begin
      p <= sum;
    end
  end

endmodule

// File: tb/tb_array_multiplier_structural.sv
// Self-checking bench for array_multiplier_structural: directed cases from the
// test plan, exhaustive sweep and random traffic against an arithmetic model.

module tb_array_multiplier_structural;

  logic       clk;
  logic       rst;
  logic [3:0] m;
  logic [3:0] q;
  logic [7:0] p;

  int total = 0;
  int bad   = 0;
  logic [7:0] model_p;

  array_multiplier_structural dut (
    .clk (clk),
    .rst (rst),
    .m   (m),
    .q   (q),
    .p   (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: p=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Present one operand pair (and reset level) for one clock edge, then check p.
  task automatic applyStimulus(input logic [3:0] mv, input logic [3:0] qv,
                               input logic rv, input string tag);
    @(negedge clk);
    m   = mv;
    q   = qv;
    rst = rv;
    @(posedge clk);
    model_p = rv ? 8'h00 : 8'(int'(mv) * int'(qv));
    #1;
    checkOutput(tag, p, model_p);
  endtask

  initial begin
    rst = 1'b1;
    m   = 4'hF;
    q   = 4'hF;

    applyStimulus(4'hF, 4'hF, 1'b1, "reset_edge1");
    applyStimulus(4'hF, 4'hF, 1'b1, "reset_edge2");
    applyStimulus(4'hF, 4'hF, 1'b0, "release_15x15");

    applyStimulus(4'd0, 4'd0, 1'b0, "0x0");
    applyStimulus(4'd1, 4'd1, 1'b0, "1x1");
    applyStimulus(4'd2, 4'd2, 1'b0, "2x2");
    applyStimulus(4'd8, 4'd8, 1'b0, "8x8");
    applyStimulus(4'd3, 4'd3, 1'b0, "3x3");

    applyStimulus(4'd15, 4'd15, 1'b0, "15x15");
    checkOutput("const_15x15", p, 8'hE1);
    applyStimulus(4'd15, 4'd1, 1'b0, "15x1");
    checkOutput("const_15x1", p, 8'h0F);
    applyStimulus(4'd7, 4'd9, 1'b0, "7x9");
    checkOutput("const_7x9", p, 8'h3F);
    applyStimulus(4'd12, 4'd5, 1'b0, "12x5");
    checkOutput("const_12x5", p, 8'h3C);

    applyStimulus(4'd5, 4'd6, 1'b0, "pipe_5x6");
    checkOutput("const_5x6", p, 8'h1E);
    applyStimulus(4'd10, 4'd10, 1'b0, "pipe_10x10");
    checkOutput("const_10x10", p, 8'h64);
    applyStimulus(4'd0, 4'd15, 1'b0, "pipe_0x15");
    checkOutput("const_0x15", p, 8'h00);

    // Operands and reset changing between edges must leave p untouched.
    applyStimulus(4'd15, 4'd15, 1'b0, "prep_E1");
    @(negedge clk);
    m   = 4'd3;
    q   = 4'd3;
    rst = 1'b1;
    #2;
    checkOutput("hold_between_edges", p, 8'hE1);
    @(posedge clk);
    #1;
    checkOutput("midstream_reset", p, 8'h00);
    applyStimulus(4'd3, 4'd3, 1'b0, "after_reset_3x3");
    checkOutput("const_after_reset", p, 8'h09);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        applyStimulus(4'(a), 4'(b), 1'b0, $sformatf("exh_%0dx%0d", a, b));
      end
    end

    for (int k = 0; k < 200; k++) begin
      applyStimulus(4'($urandom_range(15)), 4'($urandom_range(15)),
                    ($urandom_range(15) == 0), $sformatf("rand_%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
